icosoc_logic_analyzer: RTL
==========================

// Module: icosoc_logic_analyzer
// PURPOSE
//  Multi-bit trace capture for on-chip debug: samples WIDTH-bit data into a circular DEPTH-entry RAM,
//  triggers on a runtime mask/value (level or edge) match, keeps a runtime pre-trigger window,
//  then streams the DEPTH-sample window oldest-first as a byte stream to the host UART/SPI dumper.
// PARAMETERS
//  WIDTH     32   sample width in bits (1..128)
//  DEPTH     256  capture depth in samples; power of two, >= 4; DEPTH_BITS = $clog2(DEPTH)
//  TS_WIDTH  16   timestamp width in bits (used only with ICOSOC_LA_TIMESTAMP_EN)
// PORTS
//  clk         in   1           system clock; single clock domain
//  resetn      in   1           asynchronous active-low reset
//  arm         in   1           1-cycle pulse: start a new capture
//  enable      in   1           sample strobe; a sample is taken only in cycles with enable=1
//  data        in   WIDTH       sampled data
//  trig_mask   in   WIDTH       1 = bit participates in trigger compare
//  trig_value  in   WIDTH       compare value
//  trig_edge   in   1           0: level trigger; 1: trigger on transition into match
//  force_trig  in   1           unconditional trigger (honoured in WAIT only)
//  pretrig     in   DEPTH_BITS  samples kept before trigger sample; latched on arm
//  state_o     out  3           current state encoding
//  triggered   out  1           1 in POST, DONE, DUMP
//  dump_en     in   1           level request to stream the capture (honoured in DONE)
//  dump_valid  out  1           byte valid
//  dump_ready  in   1           byte accepted when valid&&ready
//  dump_data   out  8           byte payload
//  dump_last   out  1           marks final byte of the dump
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low (clk, resetn).
//  Reset: state=IDLE(0), wptr=0, dump_valid=0, dump_data=0, dump_last=0, triggered=0, match_prev=0. RAM not reset.
//  match = ((data ^ trig_value) & trig_mask) == 0; mask=0 always matches.
//  hit = enable && (trig_edge ? match && !match_prev : match) || force_trig; match_prev updates on enable, cleared on arm.
//  States: IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4 DUMP=5.
//  - IDLE/DONE: arm -> latch pre=pretrig, cnt=pretrig; go PRE (WAIT if pretrig=0). arm beats dump_en in DONE.
//  - PRE: each enable writes RAM[wptr], wptr++ (mod DEPTH), cnt--; after cnt-th sample -> WAIT. Triggers ignored.
//  - WAIT: each enable writes; on hit the current sample (zero if force_trig without enable: no write,
//    trigger address = last written) is trig_addr; cnt = DEPTH-1-pre; -> POST, or DONE if cnt=0.
//  - POST: each enable writes, cnt--; after last post sample -> DONE. Total window = DEPTH samples exactly.
//  - arm in PRE/WAIT/POST restarts capture; arm in DUMP ignored.
//  - DONE: dump_en=1 -> DUMP, rptr = trig_addr - pre (mod DEPTH).
//  - DUMP: synchronous RAM read, 1-cycle latency; byte order per sample: data LSB first (BYTES=ceil(WIDTH/8)),
//    then timestamp bytes LSB first if enabled; upper pad bits of last byte are 0.
//    dump_valid held with dump_data/dump_last stable until ready; next byte may follow back-to-back;
//    at most 1 bubble cycle between samples. dump_last on final byte of DEPTH-th sample; after its handshake -> IDLE.
//  - enable/data ignored in DONE/DUMP; trigger inputs sampled only as above.
//  - resetn low at any time: immediate return to reset values, stream aborted mid-byte.
// CONFIGURATION
//  ICOSOC_LA_TIMESTAMP_EN defined: free-running TS_WIDTH counter, +1 every clk, wraps, cleared on arm;
//   stored alongside each sample; each dumped sample = BYTES + ceil(TS_WIDTH/8) bytes.
//  Undefined: no counter, no extra RAM bits; each sample = BYTES bytes.
// TESTING (WIDTH=8, DEPTH=16, timestamp off unless stated)
//  1 data=counter 0,1,2.. every cycle, mask=FF value=10 pretrig=4, arm -> dump bytes 0C..1B, last on 1B.
//  2 trig_edge=1, data held 10 at arm for 5 samples, then 11, then 10 -> trigger on the second 10 only.
//  3 pretrig=15, trigger at 20 -> DONE right after trigger; dump 11..20, dump_last with 20.
//  4 case 1 with dump_ready high 1 cycle in 3 -> identical byte sequence, dump_data stable while stalled.
//  5 mask=FF value=AA never present, force_trig pulse in WAIT -> POST entered, triggered=1 next cycle.
//  6 resetn low mid-POST -> state_o=0, dump_valid=0 without clock; new arm captures normally.
//  (TIMESTAMP_EN, TS_WIDTH=16) case 1 -> 48 bytes, each sample followed by 2 monotonically increasing TS bytes.

Source files
------------

// File: rtl/icosoc_logic_analyzer_if.sv
// Byte stream from the logic analyzer to the host dumper, valid/ready handshake.
interface icosoc_logic_analyzer_if;
    logic       dump_valid;
    logic       dump_ready;
    logic [7:0] dump_data;
    logic       dump_last;

    modport master (output dump_valid, output dump_data, output dump_last, input dump_ready);
    modport slave  (input dump_valid, input dump_data, input dump_last, output dump_ready);
endinterface

// File: rtl/icosoc_logic_analyzer.sv
// Circular-buffer trace capture with mask/value trigger, pre-trigger window and byte-stream dump.
// Optional per-sample timestamp is enabled by defining ICOSOC_LA_TIMESTAMP_EN.
module icosoc_logic_analyzer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 256,
    parameter int TS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     arm,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         data,
    input  logic [WIDTH-1:0]         trig_mask,
    input  logic [WIDTH-1:0]         trig_value,
    input  logic                     trig_edge,
    input  logic                     force_trig,
    input  logic [$clog2(DEPTH)-1:0] pretrig,
    output logic [2:0]               state_o,
    output logic                     triggered,
    input  logic                     dump_en,
    icosoc_logic_analyzer_if.master  dump
);
    localparam int DB    = $clog2(DEPTH);
    localparam int BYTES = (WIDTH + 7) / 8;
`ifdef ICOSOC_LA_TIMESTAMP_EN
    localparam int TSB   = (TS_WIDTH + 7) / 8;
    localparam int RW    = WIDTH + TS_WIDTH;
`else
    localparam int TSB   = 0 * TS_WIDTH;
    localparam int RW    = WIDTH;
`endif
    localparam int SB    = BYTES + TSB;
    localparam int BIW   = (SB > 1) ? $clog2(SB) : 1;
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(SB - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        DONE = 3'd4,
        DUMP = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [DB-1:0]   wptr_q, wptr_d, cnt_q, cnt_d, pre_q, pre_d;
    logic [DB-1:0]   trigAddr_q, trigAddr_d, rptr_q, rptr_d, sampLeft_q, sampLeft_d;
    logic [BIW-1:0]  byteIdx_q, byteIdx_d, selIdx;
    logic            matchPrev_q, matchPrev_d, loadPend_q, loadPend_d;
    logic            valid_q, valid_d, last_q, last_d, selLast;
    logic [7:0]      dout_q, dout_d, selByte;
    logic            match, hit, wrEn, rdEn;
    logic [DB-1:0]   rdAddr, postLen;
    logic [RW-1:0]   wrWord, rdData_q;
    logic [RW-1:0]   mem [DEPTH];
    logic [SB*8-1:0] padded;

`ifdef ICOSOC_LA_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)  ts_q <= '0;
        else if (arm) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign wrWord = {ts_q, data};
`else
    assign wrWord = data;
`endif

    assign match     = ((data ^ trig_value) & trig_mask) == '0;
    assign hit       = (enable && (trig_edge ? (match && !matchPrev_q) : match)) || force_trig;
    assign postLen   = DB'(DEPTH - 1) - pre_q;
    assign state_o   = state_q;
    assign triggered = (state_q == POST) || (state_q == DONE) || (state_q == DUMP);

    assign dump.dump_valid = valid_q;
    assign dump.dump_data  = dout_q;
    assign dump.dump_last  = last_q;

    always_ff @(posedge clk) begin
        if (wrEn) mem[wptr_q] <= wrWord;
        if (rdEn) rdData_q <= mem[rdAddr];
    end

    // Sample word laid out as the byte stream: data bytes, then timestamp bytes, zero padded.
    always_comb begin
        padded = '0;
        padded[WIDTH-1:0] = rdData_q[WIDTH-1:0];
`ifdef ICOSOC_LA_TIMESTAMP_EN
        padded[BYTES*8 +: TS_WIDTH] = rdData_q[RW-1:WIDTH];
`endif
        selIdx  = loadPend_q ? '0 : byteIdx_q + 1'b1;
        selLast = (sampLeft_q == '0) && (selIdx == LAST_BYTE);
        selByte = '0;
        for (int i = 0; i < SB; i++) begin
            if (selIdx == BIW'(i)) selByte = padded[i*8 +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        trigAddr_d  = trigAddr_q;
        matchPrev_d = matchPrev_q;
        rptr_d      = rptr_q;
        sampLeft_d  = sampLeft_q;
        byteIdx_d   = byteIdx_q;
        loadPend_d  = loadPend_q;
        valid_d     = valid_q;
        dout_d      = dout_q;
        last_d      = last_q;
        wrEn        = 1'b0;
        rdEn        = 1'b0;
        rdAddr      = rptr_q;

        if (arm && state_q != DUMP) begin
            pre_d       = pretrig;
            cnt_d       = pretrig;
            matchPrev_d = 1'b0;
            state_d     = (pretrig == '0) ? WAIT : PRE;
        end else begin
            if ((state_q == PRE || state_q == WAIT || state_q == POST) && enable) begin
                wrEn        = 1'b1;
                wptr_d      = wptr_q + 1'b1;
                matchPrev_d = match;
            end
            case (state_q)
                PRE: if (enable) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == DB'(1)) state_d = WAIT;
                end
                WAIT: if (hit) begin
                    // A forced trigger without a sample points at the newest stored sample.
                    trigAddr_d = enable ? wptr_q : wptr_q - 1'b1;
                    cnt_d      = postLen;
                    state_d    = (postLen == '0) ? DONE : POST;
                end
                POST: if (enable) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == DB'(1)) state_d = DONE;
                end
                DONE: if (dump_en) begin
                    rdEn       = 1'b1;
                    rdAddr     = trigAddr_q - pre_q;
                    rptr_d     = rdAddr + 1'b1;
                    sampLeft_d = DB'(DEPTH - 1);
                    loadPend_d = 1'b1;
                    state_d    = DUMP;
                end
                DUMP: if (loadPend_q) begin
                    loadPend_d = 1'b0;
                    valid_d    = 1'b1;
                    byteIdx_d  = '0;
                    dout_d     = selByte;
                    last_d     = selLast;
                end else if (valid_q && dump.dump_ready) begin
                    if (byteIdx_q != LAST_BYTE) begin
                        byteIdx_d = selIdx;
                        dout_d    = selByte;
                        last_d    = selLast;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (sampLeft_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            rdEn       = 1'b1;
                            rptr_d     = rptr_q + 1'b1;
                            sampLeft_d = sampLeft_q - 1'b1;
                            loadPend_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            trigAddr_q  <= '0;
            matchPrev_q <= 1'b0;
            rptr_q      <= '0;
            sampLeft_q  <= '0;
            byteIdx_q   <= '0;
            loadPend_q  <= 1'b0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            trigAddr_q  <= trigAddr_d;
            matchPrev_q <= matchPrev_d;
            rptr_q      <= rptr_d;
            sampLeft_q  <= sampLeft_d;
            byteIdx_q   <= byteIdx_d;
            loadPend_q  <= loadPend_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            last_q      <= last_d;
        end
    end
endmodule
